memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 16, the word address width shared with the memory controller.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, the word data width shared with the memory controller.
REQ-003 The block SHALL have clk  input  1  clock; all state changes on posedge clk.
REQ-004 The block SHALL have rst  input  1  reset: synchronous, active-high.
REQ-005 The block SHALL have boot_done  input  1  memory controller boot complete; no grants while low.
REQ-006 The block SHALL have req0  input  1  requester 0 (evaluator) access request, level, held until ack0.
REQ-007 The block SHALL have we0  input  1  requester 0 write (1) / read (0), valid with req0.
REQ-008 The block SHALL have addr0  input  ADDR_WIDTH  requester 0 word address.
REQ-009 The block SHALL have wdata0  input  DATA_WIDTH  requester 0 write data.
REQ-010 The block SHALL have ack0  output  1  one-cycle completion pulse to requester 0.
REQ-011 The block SHALL have rdata0  output  DATA_WIDTH  registered read result for requester 0, valid while ack0 high.
REQ-012 The block SHALL have req1, we1, addr1, wdata1, ack1, rdata1 with identical widths and semantics for requester 1 (collector).
REQ-013 The block SHALL have mem_write_enable  output  1  to memory controller write_enable.
REQ-014 The block SHALL have mem_addr  output  ADDR_WIDTH  to memory controller addr.
REQ-015 The block SHALL have mem_write_data  output  DATA_WIDTH  to memory controller write_data.
REQ-016 The block SHALL have mem_read_data  input  DATA_WIDTH  from memory controller read_data; valid one cycle after address presented.
REQ-017 The block SHALL have busy  output  1  high whenever state is not IDLE.

Function
REQ-018 The block SHALL implement states IDLE, ISSUE, CAPTURE.
REQ-019 IDLE: if boot_done=1 and at least one eligible request, SHALL latch winner index, we, addr, wdata and go to ISSUE; otherwise stay in IDLE.
REQ-020 A requester SHALL be ineligible in any cycle in which its own ack is high (stale-request guard).
REQ-021 Arbitration SHALL be round-robin: single eligible request wins; with both eligible, the requester not granted last wins; last_grant resets to 1 so requester 0 wins the first tie.
REQ-022 ISSUE: SHALL drive mem_addr/mem_write_data from latched values, mem_write_enable=latched we, for exactly one cycle; next state CAPTURE.
REQ-023 CAPTURE: mem_write_enable=0, mem_addr held at latched address; on exit SHALL register mem_read_data into rdata of the winner (reads only), set winner ack=1 for one cycle, update last_grant, go to IDLE.
REQ-024 Writes SHALL leave both rdata registers unchanged.
REQ-025 Latency SHALL be fixed: request sampled in IDLE at cycle T -> ISSUE T+1 -> CAPTURE T+2 -> ack high T+3; next grant earliest sampled at T+3 for the other requester.
REQ-026 mem_write_enable SHALL be 0 in every state except ISSUE.
REQ-027 In IDLE, mem_addr SHALL hold the last latched address and mem_write_data the last latched data.
REQ-028 Request inputs SHALL be ignored outside IDLE; changes to addr/we/wdata after latching SHALL not affect the in-flight access.
REQ-029 boot_done dropping outside IDLE SHALL not abort the in-flight access; it only blocks new grants.
REQ-030 At most one ack SHALL be high in any cycle.

Reset
REQ-031 On rst: state=IDLE, ack0=ack1=0, rdata0=rdata1=0, last_grant=1, latched addr/data/we=0, hence mem_write_enable=0, mem_addr=0, mem_write_data=0, busy=0.
REQ-032 rst during ISSUE or CAPTURE SHALL abort the access with no ack; a write in ISSUE coincident with rst SHALL have mem_write_enable forced 0.

Verification
REQ-033 boot_done=0, req0=1 for 20 cycles -> no ack, mem_write_enable=0 throughout; raise boot_done -> ack0 exactly 3 cycles later.
REQ-034 req0 write addr 0x0010 data 0xDEADBEEF, then read 0x0010 -> mem_write_enable high one cycle with those values; read ack0 with rdata0=0xDEADBEEF.
REQ-035 req0 and req1 both held continuously after reset -> acks alternate 0,1,0,1 every 3 cycles, never both high.
REQ-036 req1 read of addr 0x0004 (memory 0x12345678) while rdata0 holds 0xDEADBEEF -> rdata1=0x12345678, rdata0 unchanged.
REQ-037 rst asserted in ISSUE of a write to 0x0020 -> no ack, subsequent read of 0x0020 returns prior contents, outputs at reset values.

Source files
------------

// File: rtl/memory_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory controller.
// Every grant runs a fixed IDLE -> ISSUE -> CAPTURE access and ends in a one-cycle ack.
module memory_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  boot_done,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t                state_q;
  logic                  grant_q;
  logic                  last_grant_q;
  logic                  we_q;
  logic                  mem_we_q;
  logic                  ack0_q;
  logic                  ack1_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata0_q;
  logic [DATA_WIDTH-1:0] rdata1_q;

  logic                  elig0;
  logic                  elig1;
  logic                  grant_d;
  logic                  we_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d;

  // A requester whose ack is high this cycle is still showing the request just served.
  assign elig0   = req0 & ~ack0_q;
  assign elig1   = req1 & ~ack1_q;
  assign grant_d = elig1 & (~elig0 | ~last_grant_q);
  assign we_d    = grant_d ? we1 : we0;
  assign addr_d  = grant_d ? addr1 : addr0;
  assign wdata_d = grant_d ? wdata1 : wdata0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      mem_we_q     <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      mem_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (boot_done && (elig0 || elig1)) begin
            grant_q  <= grant_d;
            we_q     <= we_d;
            mem_we_q <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            state_q  <= ISSUE;
          end
        end
        ISSUE: state_q <= CAPTURE;
        CAPTURE: begin
          if (!we_q) begin
            if (grant_q) rdata1_q <= mem_read_data;
            else         rdata0_q <= mem_read_data;
          end
          if (grant_q) ack1_q <= 1'b1;
          else         ack0_q <= 1'b1;
          last_grant_q <= grant_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Reset landing on the ISSUE cycle of a write must not reach the memory.
  assign mem_write_enable = mem_we_q & ~rst;
  assign mem_addr         = addr_q;
  assign mem_write_data   = wdata_q;
  assign ack0             = ack0_q;
  assign ack1             = ack1_q;
  assign rdata0           = rdata0_q;
  assign rdata1           = rdata1_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios plus random traffic, checked against a
// transaction-level model that schedules each grant's issue/capture/ack by cycle number.
module tb_memory_arbiter;

  logic        clk;
  logic        rst;
  logic        boot_done;
  logic        req0, we0, req1, we1;
  logic [15:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic        mem_write_enable;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        busy;

  memory_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .boot_done(boot_done),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_write_enable(mem_write_enable), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [15:0] a);
    if (a == 16'h0004) return 32'h1234_5678;
    return {16'hA5C3, a} ^ 32'h0F0F_0000;
  endfunction

  // Memory controller stand-in: synchronous write, read data one cycle after the address.
  logic [31:0] env_mem [0:65535];
  bit          env_wr  [0:65535];
  always @(posedge clk) begin
    if (mem_write_enable) begin
      env_mem[mem_addr] <= mem_write_data;
      env_wr[mem_addr]  <= 1'b1;
    end
    mem_read_data <= env_wr[mem_addr] ? env_mem[mem_addr] : init_val(mem_addr);
  end

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: one record for the most recent grant, sampled at cycle g_cyc.
  int          g_cyc = -100;
  bit          g_w, g_we;
  bit          last_g = 1'b1;
  logic [15:0] x_addr = '0;
  logic [31:0] x_wdata = '0;
  logic [31:0] x_rd0 = '0, x_rd1 = '0;
  logic [31:0] mem_m [int];

  function automatic logic [31:0] get_m(input logic [15:0] a);
    if (mem_m.exists(int'(a))) return mem_m[int'(a)];
    return init_val(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic decide();
    bit e0, e1, w;
    if (rst) begin
      g_cyc = -100; g_we = 1'b0; last_g = 1'b1;
      x_addr = '0; x_wdata = '0; x_rd0 = '0; x_rd1 = '0;
      return;
    end
    if (cyc == g_cyc + 1 && g_we) mem_m[int'(x_addr)] = x_wdata;
    if (cyc == g_cyc + 2) begin
      if (!g_we) begin
        if (g_w) x_rd1 = get_m(x_addr);
        else     x_rd0 = get_m(x_addr);
      end
      last_g = g_w;
    end
    if (cyc >= g_cyc + 3 && boot_done) begin
      e0 = req0 && !(cyc == g_cyc + 3 && g_w == 1'b0);
      e1 = req1 && !(cyc == g_cyc + 3 && g_w == 1'b1);
      if (e0 || e1) begin
        if (e0 && e1) w = (last_g == 1'b0);
        else          w = e1;
        g_cyc   = cyc;
        g_w     = w;
        g_we    = w ? we1 : we0;
        x_addr  = w ? addr1 : addr0;
        x_wdata = w ? wdata1 : wdata0;
      end
    end
  endtask

  task automatic check_cycle();
    chk("busy", busy, (cyc == g_cyc + 1) || (cyc == g_cyc + 2));
    chk("mem_we", mem_write_enable, (cyc == g_cyc + 1) && g_we);
    chk("mem_addr", mem_addr, x_addr);
    chk("mem_wdata", mem_write_data, x_wdata);
    chk("ack0", ack0, (cyc == g_cyc + 3) && !g_w);
    chk("ack1", ack1, (cyc == g_cyc + 3) && g_w);
    chk("rdata0", rdata0, x_rd0);
    chk("rdata1", rdata1, x_rd1);
    chk("ack_excl", ack0 & ack1, 1'b0);
  endtask

  task automatic tick();
    decide();
    @(posedge clk);
    cyc++;
    #1;
    check_cycle();
  endtask

  task automatic do_xfer(input bit who, input bit we, input logic [15:0] a, input logic [31:0] d);
    bit got;
    got = 1'b0;
    if (!who) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    else      begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if ((!who && ack0) || (who && ack1)) got = 1'b1;
    end
    chk("xfer_ack", got, 1'b1);
    if (!who) req0 = 1'b0; else req1 = 1'b0;
  endtask

  initial begin
    int b, n_bad, last_c;
    bit got;
    int ack_c[$];
    bit ack_w[$];

    rst = 1'b1; boot_done = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    tick(); tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_addr", mem_addr, 16'h0000);
    rst = 1'b0;

    // Grants held off until boot completes, then a fixed three-cycle turnaround.
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0004;
    n_bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ack0 || ack1 || mem_write_enable || busy) n_bad++;
    end
    chk("boot_block", n_bad, 0);
    boot_done = 1'b1;
    b = cyc;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (ack0) got = 1'b1;
    end
    chk("boot_ack_seen", got, 1'b1);
    chk("boot_latency", cyc - b, 3);
    req0 = 1'b0;
    tick();

    do_xfer(1'b0, 1'b1, 16'h0010, 32'hDEAD_BEEF);
    tick();
    do_xfer(1'b0, 1'b0, 16'h0010, 32'h0);
    chk("rd0_deadbeef", rdata0, 32'hDEAD_BEEF);
    do_xfer(1'b1, 1'b0, 16'h0004, 32'h0);
    chk("rd1_12345678", rdata1, 32'h1234_5678);
    chk("rd0_kept", rdata0, 32'hDEAD_BEEF);

    // Both requesters held from reset: strict alternation starting with requester 0.
    rst = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0001;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0002;
    tick();
    rst = 1'b0;
    b = cyc;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (ack0) begin ack_c.push_back(cyc); ack_w.push_back(1'b0); end
      if (ack1) begin ack_c.push_back(cyc); ack_w.push_back(1'b1); end
    end
    chk("rr_count", ack_c.size(), 4);
    last_c = b;
    for (int k = 0; k < ack_c.size(); k++) begin
      chk("rr_who", ack_w[k], k % 2);
      chk("rr_spacing", ack_c[k] - last_c, 3);
      last_c = ack_c[k];
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Reset during the ISSUE cycle of a write: no ack, memory untouched.
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0020; wdata0 = 32'hCAFE_F00D;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (busy) got = 1'b1;
    end
    chk("abort_reached_issue", got && mem_write_enable, 1'b1);
    req0 = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_we_forced", mem_write_enable, 1'b0);
    tick();
    rst = 1'b0;
    chk("abort_no_ack", ack0 | ack1, 1'b0);
    chk("abort_addr_rst", mem_addr, 16'h0000);
    tick(); tick(); tick();
    chk("abort_still_no_ack", ack0 | ack1, 1'b0);
    do_xfer(1'b0, 1'b0, 16'h0020, 32'h0);
    chk("abort_prior_data", rdata0, init_val(16'h0020));

    // Random traffic with held requests, late input changes, boot drops and resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) < 4) boot_done = ~boot_done;
      rst = ($urandom_range(149) == 0);
      if (ack0) req0 = 1'b0;
      else if (!req0 && $urandom_range(2) == 0) begin
        req0 = 1'b1; we0 = $urandom_range(1); addr0 = 16'($urandom_range(31)); wdata0 = $urandom;
      end else if (busy && $urandom_range(3) == 0) begin
        we0 = $urandom_range(1); addr0 = 16'($urandom_range(31)); wdata0 = $urandom;
      end
      if (ack1) req1 = 1'b0;
      else if (!req1 && $urandom_range(2) == 0) begin
        req1 = 1'b1; we1 = $urandom_range(1); addr1 = 16'($urandom_range(31)); wdata1 = $urandom;
      end else if (busy && $urandom_range(3) == 0) begin
        we1 = $urandom_range(1); addr1 = 16'($urandom_range(31)); wdata1 = $urandom;
      end
      tick();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
